// File: rtl/sda_gmem_txn_limiter_if.sv
// AXI4 gmem bus bundle shared by the action core side and the shell side
// of the outstanding-transaction limiter.
interface sda_gmem_txn_limiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
);
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [3:0]          arregion;
  logic [ID_W-1:0]     arid;
  logic [USER_W-1:0]   aruser;
  logic                arvalid;
  logic                arready;

  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic [3:0]          awregion;
  logic [ID_W-1:0]     awid;
  logic [USER_W-1:0]   awuser;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic [USER_W-1:0]   wuser;
  logic                wvalid;
  logic                wready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [ID_W-1:0]     rid;
  logic [USER_W-1:0]   ruser;
  logic                rvalid;
  logic                rready;

  logic [1:0]          bresp;
  logic [ID_W-1:0]     bid;
  logic [USER_W-1:0]   buser;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arlen, arsize, arburst, arlock, arcache,
    output arprot, arqos, arregion, arid, aruser, arvalid,
    input  arready,
    output awaddr, awlen, awsize, awburst, awlock, awcache,
    output awprot, awqos, awregion, awid, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  rdata, rresp, rlast, rid, ruser, rvalid,
    output rready,
    input  bresp, bid, buser, bvalid,
    output bready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arlock, arcache,
    input  arprot, arqos, arregion, arid, aruser, arvalid,
    output arready,
    input  awaddr, awlen, awsize, awburst, awlock, awcache,
    input  awprot, awqos, awregion, awid, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output rdata, rresp, rlast, rid, ruser, rvalid,
    input  rready,
    output bresp, bid, buser, bvalid,
    input  bready
  );
endinterface

// File: rtl/sda_gmem_txn_limiter.sv
// gmem outstanding-burst limiter with drain handshake, zero-latency pass-through.
// Optional response error capture: define SDA_GMEM_RESP_ERR_CAPTURE_EN.
module sda_gmem_txn_limiter #(
  parameter int MAX_RD_OUTSTANDING = 8,
  parameter int MAX_WR_OUTSTANDING = 8,
  parameter int CNT_WIDTH          = 8
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  sda_gmem_txn_limiter_if.slave  s_gmem,
  sda_gmem_txn_limiter_if.master m_gmem,
  input  logic                 drain_req,
  output logic                 drain_ack,
  output logic [CNT_WIDTH-1:0] rd_outstanding,
  output logic [CNT_WIDTH-1:0] wr_outstanding,
  output logic                 underflow_err,
  output logic                 resp_err,
  output logic [7:0]           resp_err_cnt,
  input  logic                 resp_err_clr
);

  localparam logic [CNT_WIDTH-1:0] RD_MAX =
    CNT_WIDTH'(MAX_RD_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] WR_MAX =
    CNT_WIDTH'(MAX_WR_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] rd_cnt, rd_nxt;
  logic [CNT_WIDTH-1:0] wr_cnt, wr_nxt;
  logic rd_full, wr_full;
  logic rd_issue, rd_retire;
  logic wr_issue, wr_retire;
  logic rd_under, wr_under;
  logic ar_open, aw_open;

  assign rd_full = (rd_cnt == RD_MAX);
  assign wr_full = (wr_cnt == WR_MAX);
  assign ar_open = ~rd_full & ~drain_req;
  assign aw_open = ~wr_full & ~drain_req;

  assign m_gmem.arvalid  = s_gmem.arvalid & ar_open;
  assign s_gmem.arready  = m_gmem.arready & ar_open;
  assign m_gmem.araddr   = s_gmem.araddr;
  assign m_gmem.arlen    = s_gmem.arlen;
  assign m_gmem.arsize   = s_gmem.arsize;
  assign m_gmem.arburst  = s_gmem.arburst;
  assign m_gmem.arlock   = s_gmem.arlock;
  assign m_gmem.arcache  = s_gmem.arcache;
  assign m_gmem.arprot   = s_gmem.arprot;
  assign m_gmem.arqos    = s_gmem.arqos;
  assign m_gmem.arregion = s_gmem.arregion;
  assign m_gmem.arid     = s_gmem.arid;
  assign m_gmem.aruser   = s_gmem.aruser;

  assign m_gmem.awvalid  = s_gmem.awvalid & aw_open;
  assign s_gmem.awready  = m_gmem.awready & aw_open;
  assign m_gmem.awaddr   = s_gmem.awaddr;
  assign m_gmem.awlen    = s_gmem.awlen;
  assign m_gmem.awsize   = s_gmem.awsize;
  assign m_gmem.awburst  = s_gmem.awburst;
  assign m_gmem.awlock   = s_gmem.awlock;
  assign m_gmem.awcache  = s_gmem.awcache;
  assign m_gmem.awprot   = s_gmem.awprot;
  assign m_gmem.awqos    = s_gmem.awqos;
  assign m_gmem.awregion = s_gmem.awregion;
  assign m_gmem.awid     = s_gmem.awid;
  assign m_gmem.awuser   = s_gmem.awuser;

  assign m_gmem.wdata    = s_gmem.wdata;
  assign m_gmem.wstrb    = s_gmem.wstrb;
  assign m_gmem.wlast    = s_gmem.wlast;
  assign m_gmem.wuser    = s_gmem.wuser;
  assign m_gmem.wvalid   = s_gmem.wvalid;
  assign s_gmem.wready   = m_gmem.wready;

  assign s_gmem.rdata    = m_gmem.rdata;
  assign s_gmem.rresp    = m_gmem.rresp;
  assign s_gmem.rlast    = m_gmem.rlast;
  assign s_gmem.rid      = m_gmem.rid;
  assign s_gmem.ruser    = m_gmem.ruser;
  assign s_gmem.rvalid   = m_gmem.rvalid;
  assign m_gmem.rready   = s_gmem.rready;

  assign s_gmem.bresp    = m_gmem.bresp;
  assign s_gmem.bid      = m_gmem.bid;
  assign s_gmem.buser    = m_gmem.buser;
  assign s_gmem.bvalid   = m_gmem.bvalid;
  assign m_gmem.bready   = s_gmem.bready;

  assign rd_issue  = m_gmem.arvalid & m_gmem.arready;
  assign rd_retire = m_gmem.rvalid & m_gmem.rready
                   & m_gmem.rlast;
  assign wr_issue  = m_gmem.awvalid & m_gmem.awready;
  assign wr_retire = m_gmem.bvalid & m_gmem.bready;

  assign rd_under = rd_retire & ~rd_issue & (rd_cnt == '0);
  assign wr_under = wr_retire & ~wr_issue & (wr_cnt == '0);

  // A retire against an empty counter holds at zero
  always_comb begin
    rd_nxt = rd_cnt;
    unique case (1'b1)
      rd_issue & ~rd_retire:  rd_nxt = rd_cnt + ONE;
      rd_retire & ~rd_issue
        & ~rd_under:          rd_nxt = rd_cnt - ONE;
      default: ;
    endcase
  end

  always_comb begin
    wr_nxt = wr_cnt;
    unique case (1'b1)
      wr_issue & ~wr_retire:  wr_nxt = wr_cnt + ONE;
      wr_retire & ~wr_issue
        & ~wr_under:          wr_nxt = wr_cnt - ONE;
      default: ;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      drain_ack     <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      rd_cnt        <= rd_nxt;
      wr_cnt        <= wr_nxt;
      drain_ack     <= drain_req & (rd_nxt == '0)
                     & (wr_nxt == '0);
      underflow_err <= underflow_err | rd_under | wr_under;
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;

`ifdef SDA_GMEM_RESP_ERR_CAPTURE_EN
  logic       r_err_evt, b_err_evt;
  logic [1:0] n_err;
  logic [7:0] cnt_base;
  logic [8:0] cnt_sum;
  logic [7:0] cnt_nxt;
  logic       err_nxt;

  assign r_err_evt = rd_retire & (m_gmem.rresp != 2'b00);
  assign b_err_evt = wr_retire & (m_gmem.bresp != 2'b00);

  // Clear wins over history but not over this cycle's errors
  always_comb begin
    n_err    = 2'(r_err_evt) + 2'(b_err_evt);
    cnt_base = resp_err_clr ? 8'h00 : resp_err_cnt;
    cnt_sum  = {1'b0, cnt_base} + 9'(n_err);
    cnt_nxt  = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
    err_nxt  = (resp_err & ~resp_err_clr) | (n_err != 2'd0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      resp_err     <= 1'b0;
      resp_err_cnt <= 8'h00;
    end else begin
      resp_err     <= err_nxt;
      resp_err_cnt <= cnt_nxt;
    end
  end
`else
  logic unused_resp_err_clr;
  assign unused_resp_err_clr = resp_err_clr;
  assign resp_err     = 1'b0;
  assign resp_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sda_gmem_txn_limiter.sv
// Directed bench for sda_gmem_txn_limiter: gating table plus
// multi-cycle sequences for full, drain, underflow, errors and reset.
module tb_sda_gmem_txn_limiter;

  localparam int CW = 8;

`ifdef SDA_GMEM_RESP_ERR_CAPTURE_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic          ap_clk;
  logic          ap_rst_n;
  logic          drain_req;
  logic          drain_ack;
  logic [CW-1:0] rd_outstanding;
  logic [CW-1:0] wr_outstanding;
  logic          underflow_err;
  logic          resp_err;
  logic [7:0]    resp_err_cnt;
  logic          resp_err_clr;

  sda_gmem_txn_limiter_if s_if ();
  sda_gmem_txn_limiter_if m_if ();

  sda_gmem_txn_limiter #(
    .MAX_RD_OUTSTANDING(2),
    .MAX_WR_OUTSTANDING(4),
    .CNT_WIDTH(CW)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .s_gmem(s_if.slave),
    .m_gmem(m_if.master),
    .drain_req(drain_req),
    .drain_ack(drain_ack),
    .rd_outstanding(rd_outstanding),
    .wr_outstanding(wr_outstanding),
    .underflow_err(underflow_err),
    .resp_err(resp_err),
    .resp_err_cnt(resp_err_cnt),
    .resp_err_clr(resp_err_clr)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  typedef struct {
    logic        arv, arr, awv, awr, drn;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        e_marv, e_sarr, e_mawv, e_sawr;
  } vec_t;

  vec_t vecs[6];
  int   hs;

  initial begin
    vecs[0] = '{1,1,1,1,0, 64'h1000, 32'hA5A5_0001, 1,1,1,1};
    vecs[1] = '{1,0,0,1,0, 64'h2040, 32'h1234_5678, 1,0,0,1};
    vecs[2] = '{0,1,1,0,0, 64'hFFFF_0000_0000_0080,
                32'hDEAD_BEEF, 0,1,1,0};
    vecs[3] = '{1,1,1,1,1, 64'h3000, 32'h0000_0000, 0,0,0,0};
    vecs[4] = '{0,0,0,0,0, 64'h0, 32'hFFFF_FFFF, 0,0,0,0};
    vecs[5] = '{1,1,0,0,1, 64'h8, 32'h0F0F_0F0F, 0,0,0,0};

    ap_rst_n     = 1'b0;
    drain_req    = 1'b0;
    resp_err_clr = 1'b0;
    s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0;
    s_if.arburst = '0; s_if.arlock = '0; s_if.arcache = '0;
    s_if.arprot = '0; s_if.arqos = '0; s_if.arregion = '0;
    s_if.arid = '0; s_if.aruser = '0; s_if.arvalid = 1'b0;
    s_if.awaddr = '0; s_if.awlen = '0; s_if.awsize = '0;
    s_if.awburst = '0; s_if.awlock = '0; s_if.awcache = '0;
    s_if.awprot = '0; s_if.awqos = '0; s_if.awregion = '0;
    s_if.awid = '0; s_if.awuser = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0;
    s_if.wuser = '0; s_if.wvalid = 1'b0;
    s_if.rready = 1'b1; s_if.bready = 1'b1;
    m_if.arready = 1'b0; m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.rdata = '0; m_if.rresp = 2'b00; m_if.rlast = 1'b0;
    m_if.rid = '0; m_if.ruser = '0; m_if.rvalid = 1'b0;
    m_if.bresp = 2'b00; m_if.bid = '0; m_if.buser = '0;
    m_if.bvalid = 1'b0;

    #3;
    chk("rst_rd_cnt", 64'(rd_outstanding), 64'd0);
    chk("rst_wr_cnt", 64'(wr_outstanding), 64'd0);
    chk("rst_drain_ack", 64'(drain_ack), 64'd0);
    chk("rst_underflow", 64'(underflow_err), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_cnt", 64'(resp_err_cnt), 64'd0);

    // Combinational gating/pass-through while counters are held at 0
    for (int i = 0; i < 6; i++) begin
      s_if.arvalid = vecs[i].arv;
      m_if.arready = vecs[i].arr;
      s_if.awvalid = vecs[i].awv;
      m_if.awready = vecs[i].awr;
      drain_req    = vecs[i].drn;
      s_if.araddr  = vecs[i].addr;
      s_if.wdata   = vecs[i].wdata;
      #1;
      chk($sformatf("v%0d_m_arvalid", i),
          64'(m_if.arvalid), 64'(vecs[i].e_marv));
      chk($sformatf("v%0d_s_arready", i),
          64'(s_if.arready), 64'(vecs[i].e_sarr));
      chk($sformatf("v%0d_m_awvalid", i),
          64'(m_if.awvalid), 64'(vecs[i].e_mawv));
      chk($sformatf("v%0d_s_awready", i),
          64'(s_if.awready), 64'(vecs[i].e_sawr));
      chk($sformatf("v%0d_araddr", i),
          m_if.araddr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i),
          64'(m_if.wdata), 64'(vecs[i].wdata));
    end

    s_if.arvalid = 1'b0; s_if.awvalid = 1'b0;
    m_if.arready = 1'b1; m_if.awready = 1'b1;
    drain_req = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();

    // Read cap at 2: third AR waits for an RLAST
    s_if.arvalid = 1'b1;
    hs = 0;
    repeat (3) begin
      #1;
      if (m_if.arvalid && s_if.arready) hs++;
      step();
    end
    chk("rd_cap_hs", 64'(hs), 64'd2);
    chk("rd_cap_cnt", 64'(rd_outstanding), 64'd2);
    chk("rd_cap_arready", 64'(s_if.arready), 64'd0);
    chk("rd_cap_m_arvalid", 64'(m_if.arvalid), 64'd0);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    #1;
    chk("rd_full_with_rlast", 64'(s_if.arready), 64'd0);
    step();
    m_if.rvalid = 1'b0;
    chk("rd_after_rlast_cnt", 64'(rd_outstanding), 64'd1);
    chk("rd_third_ready", 64'(s_if.arready), 64'd1);
    step();
    s_if.arvalid = 1'b0;
    chk("rd_third_taken", 64'(rd_outstanding), 64'd2);
    m_if.rvalid = 1'b1;
    repeat (2) step();
    m_if.rvalid = 1'b0;
    chk("rd_drained", 64'(rd_outstanding), 64'd0);
    chk("rd_no_under", 64'(underflow_err), 64'd0);

    // Simultaneous AW issue and B retire at wr_cnt=3
    s_if.awvalid = 1'b1;
    repeat (3) step();
    chk("wr_cnt3", 64'(wr_outstanding), 64'd3);
    m_if.bvalid = 1'b1;
    step();
    chk("wr_same_cycle", 64'(wr_outstanding), 64'd3);
    chk("wr_same_no_under", 64'(underflow_err), 64'd0);
    s_if.awvalid = 1'b0;
    repeat (3) step();
    m_if.bvalid = 1'b0;
    chk("wr_drained", 64'(wr_outstanding), 64'd0);

    // Drain with one read and one write in flight
    s_if.arvalid = 1'b1; s_if.awvalid = 1'b1;
    step();
    s_if.arvalid = 1'b0; s_if.awvalid = 1'b0;
    chk("dr_rd1", 64'(rd_outstanding), 64'd1);
    chk("dr_wr1", 64'(wr_outstanding), 64'd1);
    drain_req = 1'b1;
    s_if.arvalid = 1'b1; s_if.awvalid = 1'b1;
    #1;
    chk("dr_m_arvalid", 64'(m_if.arvalid), 64'd0);
    chk("dr_s_arready", 64'(s_if.arready), 64'd0);
    chk("dr_m_awvalid", 64'(m_if.awvalid), 64'd0);
    chk("dr_s_awready", 64'(s_if.awready), 64'd0);
    step();
    s_if.arvalid = 1'b0; s_if.awvalid = 1'b0;
    chk("dr_rd_held", 64'(rd_outstanding), 64'd1);
    chk("dr_ack_busy", 64'(drain_ack), 64'd0);
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1;
    step();
    m_if.rvalid = 1'b0;
    chk("dr_rd0", 64'(rd_outstanding), 64'd0);
    chk("dr_ack_wr_busy", 64'(drain_ack), 64'd0);
    m_if.bvalid = 1'b1;
    #1;
    chk("dr_ack_before_b", 64'(drain_ack), 64'd0);
    step();
    m_if.bvalid = 1'b0;
    chk("dr_ack_after_b", 64'(drain_ack), 64'd1);
    drain_req = 1'b0;
    step();
    chk("dr_ack_drop", 64'(drain_ack), 64'd0);

    // B with nothing outstanding
    m_if.bvalid = 1'b1;
    step();
    m_if.bvalid = 1'b0;
    chk("uf_wr_cnt", 64'(wr_outstanding), 64'd0);
    chk("uf_flag", 64'(underflow_err), 64'd1);
    repeat (10) step();
    chk("uf_sticky", 64'(underflow_err), 64'd1);

    // Error responses: 300 SLVERR B beats
    m_if.bresp = 2'b10;
    m_if.bvalid = 1'b1;
    repeat (300) step();
    m_if.bvalid = 1'b0;
    chk("err_flag", 64'(resp_err), 64'(ERR_ON));
    chk("err_sat", 64'(resp_err_cnt),
        ERR_ON ? 64'hFF : 64'h0);
    resp_err_clr = 1'b1;
    step();
    resp_err_clr = 1'b0;
    chk("err_clr_flag", 64'(resp_err), 64'd0);
    chk("err_clr_cnt", 64'(resp_err_cnt), 64'd0);
    resp_err_clr = 1'b1; m_if.bvalid = 1'b1;
    step();
    resp_err_clr = 1'b0; m_if.bvalid = 1'b0;
    chk("err_clr_same_flag", 64'(resp_err), 64'(ERR_ON));
    chk("err_clr_same_cnt", 64'(resp_err_cnt), 64'(ERR_ON));
    m_if.bresp = 2'b00;

    // Async reset mid-burst with two reads outstanding
    s_if.arvalid = 1'b1;
    repeat (2) step();
    chk("ar_rd2", 64'(rd_outstanding), 64'd2);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("ar_rd_clr", 64'(rd_outstanding), 64'd0);
    chk("ar_uf_clr", 64'(underflow_err), 64'd0);
    chk("ar_err_clr", 64'(resp_err_cnt), 64'd0);
    chk("ar_ack_clr", 64'(drain_ack), 64'd0);
    s_if.arvalid = 1'b0;
    step();
    ap_rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
